fetch_decode_stage: RTL and testbench

IF/ID pipeline stage directly downstream of the instruction fetch block. It registers the fetched instruction and PCPlus4, decodes the ARM instruction fields, and evaluates the condition field against an internal NZCV flags register. It computes the branch target and returns BranchAdd/PCSrc to fetch. It supports stall, flush and wrong-path squash after a taken branch.

---
 rtl/fetch_decode_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_decode_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// IF/ID pipeline register with ARM field decode, NZCV condition check and branch resolution.
// Optional macro BL_LINK_EN adds link_we/link_addr outputs for BL (R14 write-back).
module fetch_decode_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] instr_f,
    input  logic [DATA_WIDTH-1:0] pcplus4_f,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  flags_we,
    input  logic [3:0]            flags_in,
    output logic                  valid_d,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pcplus8_d,
    output logic                  cond_pass,
    output logic                  is_dp,
    output logic                  is_mem,
    output logic                  is_branch,
    output logic [3:0]            rn_d,
    output logic [3:0]            rd_d,
    output logic [3:0]            rm_d,
    output logic [11:0]           imm_d,
    output logic [DATA_WIDTH-1:0] branch_add,
    output logic                  pc_src,
    output logic                  pc_hold,
`ifdef BL_LINK_EN
    output logic                  link_we,
    output logic [DATA_WIDTH-1:0] link_addr,
`endif
    output logic [CNT_WIDTH-1:0]  branch_count
);

    logic                  valid_q, valid_d_n;
    logic [DATA_WIDTH-1:0] instr_q, instr_d_n;
    logic [DATA_WIDTH-1:0] pcplus4_q, pcplus4_d;
    logic [3:0]            flags_q, flags_d;
    logic                  squash_q, squash_d;
    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;

    logic                  flag_n, flag_z, flag_c, flag_v;
    logic                  cond_ok;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] offset;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_ok = 1'b0;
        case (instr_q[31:28])
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign op        = instr_q[27:26];
    assign valid_d   = valid_q;
    assign instr_d   = instr_q;
    assign cond_pass = cond_ok;
    assign is_dp     = valid_q && (op == 2'b00);
    assign is_mem    = valid_q && (op == 2'b01);
    assign is_branch = valid_q && (op == 2'b10) && instr_q[25];
    assign rn_d      = instr_q[19:16];
    assign rd_d      = instr_q[15:12];
    assign rm_d      = instr_q[3:0];
    assign imm_d     = instr_q[11:0];

    // ARM reads PC as the branch address + 8; offset is a signed word count.
    assign pcplus8_d  = pcplus4_q + DATA_WIDTH'(4);
    assign offset     = {{(DATA_WIDTH - 26){instr_q[23]}}, instr_q[23:0], 2'b00};
    assign branch_add = pcplus8_d + offset;

    assign pc_src       = valid_q && is_branch && cond_ok && !stall && !flush;
    assign pc_hold      = stall;
    assign branch_count = branch_count_q;

`ifdef BL_LINK_EN
    assign link_we   = pc_src && instr_q[24];
    assign link_addr = pcplus4_q;
`endif

    always_comb begin
        valid_d_n      = valid_q;
        instr_d_n      = instr_q;
        pcplus4_d      = pcplus4_q;
        squash_d       = squash_q;
        flags_d        = flags_we ? flags_in : flags_q;
        branch_count_d = branch_count_q;

        if (flush) begin
            valid_d_n = 1'b0;
            instr_d_n = '0;
        end else if (stall) begin
            // hold everything
        end else if (squash_q) begin
            valid_d_n = 1'b0;
            instr_d_n = '0;
            squash_d  = 1'b0;
        end else begin
            valid_d_n = 1'b1;
            instr_d_n = instr_f;
            pcplus4_d = pcplus4_f;
        end

        // A redirect marks the next loaded slot as wrong-path.
        if (pc_src) begin
            squash_d = 1'b1;
            if (branch_count_q != {CNT_WIDTH{1'b1}}) begin
                branch_count_d = branch_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q        <= 1'b0;
            instr_q        <= '0;
            pcplus4_q      <= '0;
            flags_q        <= 4'b0000;
            squash_q       <= 1'b0;
            branch_count_q <= '0;
        end else begin
            valid_q        <= valid_d_n;
            instr_q        <= instr_d_n;
            pcplus4_q      <= pcplus4_d;
            flags_q        <= flags_d;
            squash_q       <= squash_d;
            branch_count_q <= branch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage (CNT_WIDTH=2 so counter saturation is reachable).
module tb_fetch_decode_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;
    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] instr_f, pcplus4_f;
    logic          stall, flush, flags_we;
    logic [3:0]    flags_in;
    logic          valid_d, cond_pass, is_dp, is_mem, is_branch, pc_src, pc_hold;
    logic [DW-1:0] instr_d, pcplus8_d, branch_add;
    logic [3:0]    rn_d, rd_d, rm_d;
    logic [11:0]   imm_d;
    logic [CW-1:0] branch_count;
`ifdef BL_LINK_EN
    logic          link_we;
    logic [DW-1:0] link_addr;
`endif

    int checks = 0;
    int errors = 0;

    fetch_decode_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .instr_f(instr_f), .pcplus4_f(pcplus4_f),
        .stall(stall), .flush(flush), .flags_we(flags_we), .flags_in(flags_in),
        .valid_d(valid_d), .instr_d(instr_d), .pcplus8_d(pcplus8_d), .cond_pass(cond_pass),
        .is_dp(is_dp), .is_mem(is_mem), .is_branch(is_branch),
        .rn_d(rn_d), .rd_d(rd_d), .rm_d(rm_d), .imm_d(imm_d),
        .branch_add(branch_add), .pc_src(pc_src), .pc_hold(pc_hold),
`ifdef BL_LINK_EN
        .link_we(link_we), .link_addr(link_addr),
`endif
        .branch_count(branch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cond_vec [10] = '{32'h03A02005, 32'h13A02005, 32'h43A02005, 32'h63A02005,
                                   32'h83A02005, 32'hA3A02005, 32'hB3A02005, 32'hC3A02005,
                                   32'hD3A02005, 32'hF3A02005};
    logic        cond_exp [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        reset = 1'b0; instr_f = '0; pcplus4_f = '0;
        stall = 1'b0; flush = 1'b0; flags_we = 1'b0; flags_in = 4'b0000;
        #12;
        check("rst_valid", {31'b0, valid_d}, 32'd0);
        check("rst_instr", instr_d, 32'd0);
        check("rst_pc_src", {31'b0, pc_src}, 32'd0);
        check("rst_cond", {31'b0, cond_pass}, 32'd0);
        check("rst_count", {30'b0, branch_count}, 32'd0);

        // MOV r2,#5
        reset = 1'b1; instr_f = 32'hE3A02005; pcplus4_f = 32'h8;
        step();
        check("mov_valid", {31'b0, valid_d}, 32'd1);
        check("mov_is_dp", {31'b0, is_dp}, 32'd1);
        check("mov_is_mem", {31'b0, is_mem}, 32'd0);
        check("mov_is_br", {31'b0, is_branch}, 32'd0);
        check("mov_rd", {28'b0, rd_d}, 32'd2);
        check("mov_imm", {20'b0, imm_d}, 32'h5);
        check("mov_cond", {31'b0, cond_pass}, 32'd1);
        check("mov_pc8", pcplus8_d, 32'hC);
        check("mov_pc_src", {31'b0, pc_src}, 32'd0);

        // B . (backwards by 2 words)
        instr_f = 32'hEAFFFFFE; pcplus4_f = 32'h14;
        step();
        check("b_add", branch_add, 32'h10);
        check("b_pc_src", {31'b0, pc_src}, 32'd1);
        instr_f = NOP; pcplus4_f = 32'h18;
        step();
        check("b_count", {30'b0, branch_count}, 32'd1);
        step();
        check("b_squash_valid", {31'b0, valid_d}, 32'd0);
        check("b_squash_instr", instr_d, 32'd0);
        instr_f = 32'hE3A02005; pcplus4_f = 32'h20;
        step();
        check("b_reload_valid", {31'b0, valid_d}, 32'd1);
        check("b_reload_instr", instr_d, 32'hE3A02005);

        // BEQ with Z clear, then set Z while stalled
        instr_f = 32'h0A000001; pcplus4_f = 32'h8;
        step();
        check("beq_is_br", {31'b0, is_branch}, 32'd1);
        check("beq_nz_cond", {31'b0, cond_pass}, 32'd0);
        check("beq_nz_pc_src", {31'b0, pc_src}, 32'd0);
        stall = 1'b1; flags_we = 1'b1; flags_in = 4'b0100; instr_f = NOP;
        #1;
        check("beq_no_bypass", {31'b0, cond_pass}, 32'd0);
        step();
        flags_we = 1'b0; stall = 1'b0;
        #1;
        check("beq_z_cond", {31'b0, cond_pass}, 32'd1);
        check("beq_z_pc_src", {31'b0, pc_src}, 32'd1);
        check("beq_z_add", branch_add, 32'h10);
        check("beq_held", instr_d, 32'h0A000001);
        pcplus4_f = 32'hC;
        step();
        check("beq_count", {30'b0, branch_count}, 32'd2);
        step();
        check("beq_squash", {31'b0, valid_d}, 32'd0);

        // Taken branch held by stall for 3 cycles
        instr_f = 32'hEAFFFFFE; pcplus4_f = 32'h14;
        step();
        stall = 1'b1; instr_f = NOP;
        #1;
        check("st_pc_hold", {31'b0, pc_hold}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("st_pc_src", {31'b0, pc_src}, 32'd0);
            step();
            check("st_instr", instr_d, 32'hEAFFFFFE);
        end
        check("st_count", {30'b0, branch_count}, 32'd2);
        stall = 1'b0;
        #1;
        check("st_release", {31'b0, pc_src}, 32'd1);
        step();
        check("st_one_pulse", {31'b0, pc_src}, 32'd0);
        check("st_count3", {30'b0, branch_count}, 32'd3);
        step();
        check("st_squash", {31'b0, valid_d}, 32'd0);
        instr_f = 32'hE3A02005;
        step();
        stall = 1'b1; flush = 1'b1;
        #1;
        check("fl_pc_src", {31'b0, pc_src}, 32'd0);
        step();
        check("fl_valid", {31'b0, valid_d}, 32'd0);
        check("fl_is_dp_gated", {31'b0, is_dp}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Condition codes with N=1 Z=0 C=0 V=1
        flags_we = 1'b1; flags_in = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            instr_f = cond_vec[i];
            step();
            flags_we = 1'b0;
            check("cond_code", {31'b0, cond_pass}, {31'b0, cond_exp[i]});
        end

        // Class decode
        instr_f = 32'hE5912004;
        step();
        check("ldr_is_mem", {31'b0, is_mem}, 32'd1);
        check("ldr_rn", {28'b0, rn_d}, 32'd1);
        check("ldr_rm", {28'b0, rm_d}, 32'd4);
        instr_f = 32'hE8BD0001;
        step();
        check("ldm_none", {29'b0, is_dp, is_mem, is_branch}, 32'd0);
        instr_f = 32'hEC000000;
        step();
        check("op11_none", {29'b0, is_dp, is_mem, is_branch}, 32'd0);

        // Counter saturation
        instr_f = 32'hEAFFFFFE; pcplus4_f = 32'h14;
        step();
        check("sat_pc_src", {31'b0, pc_src}, 32'd1);
        instr_f = NOP;
        step();
        check("sat_count", {30'b0, branch_count}, 32'd3);
        step();

        // BL
        instr_f = 32'hEB000002; pcplus4_f = 32'h24;
        step();
        check("bl_add", branch_add, 32'h30);
        check("bl_pc_src", {31'b0, pc_src}, 32'd1);
`ifdef BL_LINK_EN
        check("bl_link_we", {31'b0, link_we}, 32'd1);
        check("bl_link_addr", link_addr, 32'h24);
`endif
        instr_f = NOP;
        step();
        check("pre_rst_valid", {31'b0, valid_d}, 32'd1);

        // Asynchronous reset away from the clock edge
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, valid_d}, 32'd0);
        check("arst_instr", instr_d, 32'd0);
        check("arst_count", {30'b0, branch_count}, 32'd0);
        check("arst_pc8", pcplus8_d, 32'h4);
        check("arst_pc_src", {31'b0, pc_src}, 32'd0);
        instr_f = 32'hE3A02005; pcplus4_f = 32'h8;
        #10;
        reset = 1'b1;
        step();
        check("post_rst_load", instr_d, 32'hE3A02005);
        check("post_rst_valid", {31'b0, valid_d}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
